// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// default bus widths, FSM state encoding and the conflict counter ceiling.
package mem_port_arbiter_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_DM_BUSY = 2'd2;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_port_arbiter_sat_counter16.sv
// 16-bit saturating event counter with synchronous clear; holds at CNT_MAX
// instead of wrapping so a long-running stall never reads back as small.
module sat_counter16
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        clr_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear wins, otherwise step until the ceiling is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access.
// Data has fixed priority; each access holds the port until mem_ready, then
// the FSM returns to IDLE for one cycle while the matching done pulses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [15:0]   conflict_cnt
);

    logic [1:0]    state_q,     state_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_done_q,   if_done_d;
    logic          dm_done_q,   dm_done_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] dm_rdata_q,  dm_rdata_d;
    logic          kill_q,      kill_d;

    logic dm_elig;
    logic if_elig;
    logic cnt_en;

    // A requester whose done is high this cycle is still holding req; mask it
    // so the finished access is not issued a second time.
    assign dm_elig = dm_req && !dm_done_q;
    assign if_elig = if_req && !if_kill && !if_done_q;

    // Fetch is counted as blocked while data owns the port, or when data
    // wins the grant over a pending fetch.
    assign cnt_en = (if_req && !if_kill && (state_q == ST_DM_BUSY)) ||
                    ((state_q == ST_IDLE) && dm_elig && if_req);

    // FSM next state, grant latching and completion capture.
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        kill_d      = kill_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (dm_elig) begin
                    state_d     = ST_DM_BUSY;
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                end else if (if_elig) begin
                    state_d     = ST_IF_BUSY;
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                end
            end
            ST_IF_BUSY: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    kill_d  = 1'b0;
                    // A redirect arriving in the completion cycle also discards the data.
                    if (!kill_q && !if_kill) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    kill_d = kill_q || if_kill;
                end
            end
            ST_DM_BUSY: begin
                if (mem_ready) begin
                    state_d   = ST_IDLE;
                    dm_done_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            kill_q      <= kill_d;
        end
    end

    sat_counter16 u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (cnt_en),
        .clr_i (1'b0),
        .cnt_o (conflict_cnt)
    );

    assign mem_req   = (state_q == ST_IF_BUSY) || (state_q == ST_DM_BUSY);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule
